// File: rtl/iterative_align_shifter.sv
// Multi-cycle shifter for FPU alignment (right shift, sticky) and normalisation (left to leading one).
// Latency: done in the cycle after edge T+k (k = ceil(steps/CHUNK), shifts performed, or 0).
// Backpressure: ready only in IDLE; start outside IDLE is ignored, nothing is queued.
module iterative_align_shifter #(
  parameter int WORD_LENGTH = 8,
  parameter int STEP_WIDTH  = 4,
  parameter int CHUNK       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic [STEP_WIDTH-1:0]  steps,
  input  logic                   fill,
  output logic                   ready,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] data_out,
  output logic [STEP_WIDTH-1:0]  shift_count,
  output logic                   lost,
  output logic                   zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] M_LSL  = 2'b00;
  localparam logic [1:0] M_NORM = 2'b11;

  localparam logic [STEP_WIDTH-1:0] ONE_S = 1;

  logic [1:0]             state_q, state_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic [STEP_WIDTH-1:0]  rem_q, rem_d;
  logic [STEP_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   lost_q, lost_d;
  logic [1:0]             mode_q, mode_d;
  logic                   fill_q, fill_d;

  // Next-state logic: accept in IDLE, step up to CHUNK positions per edge in SHIFT.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    mode_d  = mode_q;
    fill_d  = fill_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          data_d = data_in;
          rem_d  = steps;
          cnt_d  = '0;
          lost_d = 1'b0;
          mode_d = mode;
          fill_d = fill;
          // Zero shift or an already-normalised operand needs no SHIFT cycle.
          if (steps == '0 || (mode == M_NORM && data_in[WORD_LENGTH-1]))
            state_d = DONE;
          else
            state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (mode_q == M_NORM) begin
          // Normalise moves one position per edge so it can stop exactly at the leading one.
          lost_d  = lost_q | data_q[WORD_LENGTH-1];
          data_d  = {data_q[WORD_LENGTH-2:0], 1'b0};
          rem_d   = rem_q - ONE_S;
          cnt_d   = cnt_q + ONE_S;
          if (data_d[WORD_LENGTH-1] || rem_d == '0)
            state_d = DONE;
        end else begin
          // Unrolled single-bit steps, each gated on work remaining: n = min(CHUNK, remaining).
          for (int i = 0; i < CHUNK; i++) begin
            if (rem_d != '0) begin
              if (mode_q == M_LSL) begin
                lost_d = lost_d | data_d[WORD_LENGTH-1];
                data_d = {data_d[WORD_LENGTH-2:0], 1'b0};
              end else begin
                lost_d = lost_d | data_d[0];
                // Mode 01 shifts in zero; mode 10 shifts in the latched sign.
                data_d = {(mode_q[1] & fill_q), data_d[WORD_LENGTH-1:1]};
              end
              rem_d = rem_d - ONE_S;
              cnt_d = cnt_d + ONE_S;
            end
          end
          if (rem_d == '0)
            state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
      mode_q  <= 2'b00;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign data_out    = data_q;
  assign shift_count = cnt_q;
  assign lost        = lost_q;
  assign zero        = (data_q == '0);

endmodule

// File: tb/tb_iterative_align_shifter.sv
// Directed bench for iterative_align_shifter with hand-computed expectations.
// Checks reset state, per-mode results, latency, ignored start, mid-operation reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_iterative_align_shifter;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [7:0] data_in;
  logic [3:0] steps;
  logic       fill;
  logic       ready;
  logic       done;
  logic [7:0] data_out;
  logic [3:0] shift_count;
  logic       lost;
  logic       zero;

  int n_cmp = 0;
  int n_bad = 0;

  iterative_align_shifter #(
    .WORD_LENGTH(8),
    .STEP_WIDTH (4),
    .CHUNK      (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .data_in    (data_in),
    .steps      (steps),
    .fill       (fill),
    .ready      (ready),
    .done       (done),
    .data_out   (data_out),
    .shift_count(shift_count),
    .lost       (lost),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency k, check results and the single done pulse.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [7:0] d,
                        input logic [3:0] s, input logic f, input int k,
                        input logic [7:0] ed, input logic [3:0] ec,
                        input logic el, input logic ez, input bit poke);
    int j;
    j = 0;
    while (!ready && j < 100) begin
      @(negedge clk);
      j++;
    end
    chk({tag, ".ready_in"}, {31'd0, ready}, 32'd1);
    mode = m; data_in = d; steps = s; fill = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, {31'd0, ready}, 32'd0);
    j = 0;
    while (!done && j < 60) begin
      if (poke && j == 1) begin
        start = 1'b1; mode = 2'b00; data_in = 8'h55; steps = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    chk({tag, ".k"}, j, k);
    chk({tag, ".data"}, {24'd0, data_out}, {24'd0, ed});
    chk({tag, ".cnt"}, {28'd0, shift_count}, {28'd0, ec});
    chk({tag, ".lost"}, {31'd0, lost}, {31'd0, el});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    @(negedge clk);
    chk({tag, ".done_once"}, {31'd0, done}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, ready}, 32'd1);
    chk({tag, ".stable"}, {24'd0, data_out}, {24'd0, ed});
  endtask

  initial begin
    int dones;
    reset = 1'b0; start = 1'b0; mode = 2'b00; data_in = 8'h00; steps = 4'd0; fill = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst.ready", {31'd0, ready}, 32'd1);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.data", {24'd0, data_out}, 32'd0);
    chk("rst.cnt", {28'd0, shift_count}, 32'd0);
    chk("rst.lost", {31'd0, lost}, 32'd0);
    chk("rst.zero", {31'd0, zero}, 32'd1);
    reset = 1'b1;
    @(negedge clk);

    //      tag       mode   data   steps fill k  data   cnt   lost  zero poke
    run_op("lsr3",    2'b01, 8'hB6, 4'd3,  0, 2, 8'h16, 4'd3, 1'b1, 1'b0, 0);
    run_op("asr96",   2'b10, 8'h96, 4'd4,  1, 2, 8'hF9, 4'd4, 1'b1, 1'b0, 0);
    run_op("asr90",   2'b10, 8'h90, 4'd4,  1, 2, 8'hF9, 4'd4, 1'b0, 1'b0, 0);
    run_op("norm0A",  2'b11, 8'h0A, 4'd15, 0, 4, 8'hA0, 4'd4, 1'b0, 1'b0, 0);
    run_op("norm00",  2'b11, 8'h00, 4'd5,  0, 5, 8'h00, 4'd5, 1'b0, 1'b1, 0);
    run_op("normMSB", 2'b11, 8'h81, 4'd7,  0, 0, 8'h81, 4'd0, 1'b0, 1'b0, 0);
    run_op("lsl1",    2'b00, 8'hC3, 4'd1,  0, 1, 8'h86, 4'd1, 1'b1, 1'b0, 0);
    run_op("lsl0",    2'b00, 8'hC3, 4'd0,  0, 0, 8'hC3, 4'd0, 1'b0, 1'b0, 0);
    run_op("lsr12",   2'b01, 8'hFF, 4'd12, 0, 6, 8'h00, 4'd12, 1'b1, 1'b1, 1);
    run_op("asr9",    2'b10, 8'h80, 4'd9,  1, 5, 8'hFF, 4'd9, 1'b1, 1'b0, 0);
    run_op("lsl5",    2'b00, 8'h07, 4'd5,  0, 3, 8'hE0, 4'd5, 1'b0, 1'b0, 0);

    // Reset arriving on the second SHIFT edge aborts without a done pulse.
    mode = 2'b01; data_in = 8'hFF; steps = 4'd12; fill = 1'b0; start = 1'b1;
    @(negedge clk);            // accepted
    start = 1'b0;
    @(negedge clk);            // first SHIFT edge passed
    reset = 1'b0;
    @(negedge clk);            // second SHIFT edge sees reset
    reset = 1'b1;
    chk("abort.ready", {31'd0, ready}, 32'd1);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.data", {24'd0, data_out}, 32'd0);
    chk("abort.cnt", {28'd0, shift_count}, 32'd0);
    chk("abort.lost", {31'd0, lost}, 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort.no_done", dones, 0);
    run_op("post",    2'b01, 8'hB6, 4'd3,  0, 2, 8'h16, 4'd3, 1'b1, 1'b0, 0);

    // Start on the same edge as reset: reset wins.
    mode = 2'b00; data_in = 8'h01; steps = 4'd3; start = 1'b1; reset = 1'b0;
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    chk("same.ready", {31'd0, ready}, 32'd1);
    chk("same.data", {24'd0, data_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
